pong_engine: RTL and testbench

Frame-rate game-state engine for the two-player Pong design. Sits directly upstream of the VGA renderer: it consumes the four paddle buttons and a start input, advances paddle, ball and score state once per video frame, and presents registered object coordinates and scores for the renderer to draw. All state is on the single system clock; the renderer only reads outputs.

---
 rtl/pong_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// pong_engine: frame-rate paddle, ball and score state for the Pong renderer.
// Buttons are synchronized; all game state advances only on frame_tick.
module pong_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       up1,
  input  logic       down1,
  input  logic       up2,
  input  logic       down2,
  input  logic       start,
  output logic [8:0] paddle1_y,
  output logic [8:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       playing,
  output logic       game_over
);

  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_POINT = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0] STEP    = 11'(PADDLE_STEP);
  localparam logic [10:0] PAD_MAX = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] PH      = 11'(PADDLE_H);
  localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
  localparam logic [10:0] SPD     = 11'(BALL_SPEED);
  localparam logic [10:0] Y_BOT   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] X_RGT   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] L_FACE  = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] R_FACE  = 11'(P2_X - BALL_SIZE);

  localparam logic [8:0]    PAD_RST    = 9'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0]    BX_C       = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0]    BY_C       = 9'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

  logic [4:0] meta;
  logic [4:0] sync;
  logic       s_up1;
  logic       s_dn1;
  logic       s_up2;
  logic       s_dn2;
  logic       s_start;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {up1, down1, up2, down2, start};
      sync <= meta;
    end
  end

  assign {s_up1, s_dn1, s_up2, s_dn2, s_start} = sync;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          dx_right;
  logic          dy_down;

  logic [1:0]    state_n;
  logic [CW-1:0] cnt_n;
  logic          dx_n;
  logic          dy_n;
  logic [8:0]    p1_n;
  logic [8:0]    p2_n;
  logic [9:0]    bx_n;
  logic [8:0]    by_n;
  logic [3:0]    s1_n;
  logic [3:0]    s2_n;

  logic [8:0]    p1_mv;
  logic [8:0]    p2_mv;
  logic [10:0]   bx_w;
  logic [10:0]   by_w;

  function automatic logic [8:0] move_paddle(
    input logic [8:0] y,
    input logic       up,
    input logic       dn
  );
    logic [10:0] y_w;
    y_w = {2'b00, y};
    move_paddle = y;
    unique case ({up, dn})
      2'b10: move_paddle = (y_w >= STEP) ? 9'(y_w - STEP) : 9'd0;
      2'b01: move_paddle = (y_w + STEP >= PAD_MAX) ? PAD_MAX[8:0]
                                                  : 9'(y_w + STEP);
      default: ;
    endcase
  endfunction

  function automatic logic overlap(
    input logic [8:0] by,
    input logic [8:0] py
  );
    overlap = ({2'b00, by} + BSZ > {2'b00, py}) &&
              ({2'b00, by} < {2'b00, py} + PH);
  endfunction

  assign p1_mv = move_paddle(paddle1_y, s_up1, s_dn1);
  assign p2_mv = move_paddle(paddle2_y, s_up2, s_dn2);
  assign bx_w  = {1'b0, ball_x};
  assign by_w  = {2'b00, ball_y};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dx_n    = dx_right;
    dy_n    = dy_down;
    p1_n    = paddle1_y;
    p2_n    = paddle2_y;
    bx_n    = ball_x;
    by_n    = ball_y;
    s1_n    = score1;
    s2_n    = score2;
    if (frame_tick) begin
      unique case (state)
        S_SERVE: begin
          p1_n = p1_mv;
          p2_n = p2_mv;
          bx_n = BX_C;
          by_n = BY_C;
          if (cnt == SERVE_LAST) begin
            cnt_n   = '0;
            state_n = S_PLAY;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_PLAY: begin
          p1_n = p1_mv;
          p2_n = p2_mv;
          if (!dy_down && by_w <= SPD) begin
            by_n = '0;
            dy_n = 1'b1;
          end else if (dy_down && by_w + SPD >= Y_BOT) begin
            by_n = Y_BOT[8:0];
            dy_n = 1'b0;
          end else if (dy_down) begin
            by_n = 9'(by_w + SPD);
          end else begin
            by_n = 9'(by_w - SPD);
          end
          // Collision uses this tick's paddle position but the old ball_y.
          if (!dx_right) begin
            if (bx_w >= L_FACE && bx_w <= L_FACE + SPD &&
                overlap(ball_y, p1_mv)) begin
              bx_n = L_FACE[9:0];
              dx_n = 1'b1;
            end else if (bx_w <= SPD) begin
              s2_n    = score2 + 4'd1;
              state_n = S_POINT;
            end else begin
              bx_n = 10'(bx_w - SPD);
            end
          end else begin
            if (bx_w <= R_FACE && bx_w + SPD >= R_FACE &&
                overlap(ball_y, p2_mv)) begin
              bx_n = R_FACE[9:0];
              dx_n = 1'b0;
            end else if (bx_w + SPD >= X_RGT) begin
              s1_n    = score1 + 4'd1;
              state_n = S_POINT;
            end else begin
              bx_n = 10'(bx_w + SPD);
            end
          end
        end
        S_POINT: begin
          // dx still points at the conceding side, so the serve goes there.
          bx_n    = BX_C;
          by_n    = BY_C;
          cnt_n   = '0;
          state_n = (score1 == WIN || score2 == WIN) ? S_OVER : S_SERVE;
        end
        S_OVER: begin
          if (s_start) begin
            state_n = S_SERVE;
            cnt_n   = '0;
            dx_n    = 1'b1;
            dy_n    = 1'b1;
            p1_n    = PAD_RST;
            p2_n    = PAD_RST;
            bx_n    = BX_C;
            by_n    = BY_C;
            s1_n    = '0;
            s2_n    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_SERVE;
      cnt       <= '0;
      dx_right  <= 1'b1;
      dy_down   <= 1'b1;
      paddle1_y <= PAD_RST;
      paddle2_y <= PAD_RST;
      ball_x    <= BX_C;
      ball_y    <= BY_C;
      score1    <= '0;
      score2    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dx_right  <= dx_n;
      dy_down   <= dy_n;
      paddle1_y <= p1_n;
      paddle2_y <= p2_n;
      ball_x    <= bx_n;
      ball_y    <= by_n;
      score1    <= s1_n;
      score2    <= s2_n;
    end
  end

  assign playing   = (state == S_PLAY);
  assign game_over = (state == S_OVER);

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: scoreboard bench for pong_engine against a behavioural
// model of the game rules, plus anchored checks on key frames.
module tb_pong_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       up1;
  logic       down1;
  logic       up2;
  logic       down2;
  logic       start;
  logic [8:0] paddle1_y;
  logic [8:0] paddle2_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       playing;
  logic       game_over;

  always #5 clock = ~clock;

  pong_engine dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .up1        (up1),
    .down1      (down1),
    .up2        (up2),
    .down2      (down2),
    .start      (start),
    .paddle1_y  (paddle1_y),
    .paddle2_y  (paddle2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score1     (score1),
    .score2     (score2),
    .playing    (playing),
    .game_over  (game_over)
  );

  typedef struct {
    int p1;
    int p2;
    int bx;
    int by;
    int s1;
    int s2;
    int pl;
    int go;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int m_p1, m_p2, m_bx, m_by, m_dxr, m_dyd;
  int m_s1, m_s2, m_cnt, m_st;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p1  = 208;
    m_p2  = 208;
    m_bx  = 316;
    m_by  = 236;
    m_dxr = 1;
    m_dyd = 1;
    m_s1  = 0;
    m_s2  = 0;
    m_cnt = 0;
    m_st  = 0;
  endtask

  function automatic int pad(input int y, input bit u, input bit d);
    if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
    if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function automatic bit hits(input int by, input int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_step(input logic [4:0] b);
    bit u1, d1, u2, d2, st;
    int nby, ndy;
    {u1, d1, u2, d2, st} = b;
    if (m_st == 3) begin
      if (st) model_reset();
    end else if (m_st == 2) begin
      m_bx = 316;
      m_by = 236;
      m_st = (m_s1 == 9 || m_s2 == 9) ? 3 : 0;
    end else begin
      m_p1 = pad(m_p1, u1, d1);
      m_p2 = pad(m_p2, u2, d2);
      if (m_st == 0) begin
        m_cnt++;
        if (m_cnt == 60) begin
          m_cnt = 0;
          m_st  = 1;
        end
      end else begin
        ndy = m_dyd;
        if (m_dyd == 0 && m_by <= 2) begin
          nby = 0; ndy = 1;
        end else if (m_dyd == 1 && m_by >= 470) begin
          nby = 472; ndy = 0;
        end else begin
          nby = (m_dyd == 1) ? m_by + 2 : m_by - 2;
        end
        if (m_dxr == 0) begin
          if (m_bx >= 24 && m_bx <= 26 && hits(m_by, m_p1)) begin
            m_bx = 24; m_dxr = 1;
          end else if (m_bx <= 2) begin
            m_s2++; m_st = 2;
          end else m_bx -= 2;
        end else begin
          if (m_bx >= 606 && m_bx <= 608 && hits(m_by, m_p2)) begin
            m_bx = 608; m_dxr = 0;
          end else if (m_bx >= 630) begin
            m_s1++; m_st = 2;
          end else m_bx += 2;
        end
        m_by  = nby;
        m_dyd = ndy;
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.p1 = m_p1; e.p2 = m_p2; e.bx = m_bx; e.by = m_by;
    e.s1 = m_s1; e.s2 = m_s2;
    e.pl = (m_st == 1) ? 1 : 0;
    e.go = (m_st == 3) ? 1 : 0;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("paddle1_y", paddle1_y, e.p1);
    check("paddle2_y", paddle2_y, e.p2);
    check("ball_x", ball_x, e.bx);
    check("ball_y", ball_y, e.by);
    check("score1", score1, e.s1);
    check("score2", score2, e.s2);
    check("playing", playing, e.pl);
    check("game_over", game_over, e.go);
  endtask

  // Inputs settle three edges before the tick so the synchronizer is flushed.
  task automatic frame(input logic [4:0] b);
    {up1, down1, up2, down2, start} = b;
    repeat (3) @(negedge clock);
    frame_tick = 1'b1;
    model_step(b);
    sb.push_back(snap());
    @(negedge clock);
    frame_tick = 1'b0;
    compare_out();
  endtask

  task automatic do_reset(input logic with_tick);
    {up1, down1, up2, down2, start} = 5'b0;
    reset      = 1'b1;
    frame_tick = with_tick;
    @(negedge clock);
    reset      = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    sb.delete();
    check("rst_p1", paddle1_y, 208);
    check("rst_p2", paddle2_y, 208);
    check("rst_bx", ball_x, 316);
    check("rst_by", ball_y, 236);
    check("rst_s1", score1, 0);
    check("rst_s2", score2, 0);
    check("rst_play", playing, 0);
    check("rst_over", game_over, 0);
  endtask

  function automatic logic [4:0] chase_buttons();
    int t1, t2;
    bit u1, d1, u2, d2;
    t1 = (m_by >= 200) ? 0 : 416;
    t2 = m_by - 28;
    if (t2 < 0) t2 = 0;
    if (t2 > 416) t2 = 416;
    u1 = m_p1 > t1;
    d1 = m_p1 < t1;
    u2 = m_p2 > t2 + 2;
    d2 = m_p2 < t2 - 2;
    return {u1, d1, u2, d2, 1'b0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    frame_tick = 1'b0;
    {up1, down1, up2, down2, start} = 5'b0;
    @(negedge clock);
    do_reset(1'b0);

    for (int i = 1; i <= 5; i++) begin
      frame(5'b00000);
      check("idle_play", playing, 0);
    end
    check("idle_bx", ball_x, 316);

    do_reset(1'b0);
    for (int i = 1; i <= 60; i++) begin
      frame(5'b10010);
      if (i == 51) check("p1_t51", paddle1_y, 4);
      if (i == 52) check("p1_t52", paddle1_y, 0);
      if (i == 52) check("p2_t52", paddle2_y, 416);
      if (i == 59) check("play_t59", playing, 0);
    end
    check("play_t60", playing, 1);
    check("p1_clamp", paddle1_y, 0);
    for (int i = 0; i < 4; i++) frame(5'b11000);
    check("p1_both", paddle1_y, 0);

    do_reset(1'b0);
    for (int i = 0; i < 60; i++) frame(5'b00000);
    check("launch_play", playing, 1);
    frame(5'b00000);
    check("launch_bx", ball_x, 318);
    check("launch_by", ball_y, 238);
    for (int i = 0; i < 200 && m_by != 472; i++) frame(5'b00000);
    check("bounce_y", ball_y, 472);
    frame(5'b00000);
    check("after_bounce", ball_y, 470);

    do_reset(1'b1);

    for (int i = 1; i <= 206; i++) frame((i <= 44) ? 5'b00010 : 5'b00000);
    check("hit_p2y", paddle2_y, 384);
    check("hit_bx", ball_x, 608);
    check("hit_s1", score1, 0);
    frame(5'b00000);
    check("hit_left", ball_x, 606);

    for (int i = 0; i < 600 && m_s2 == 0; i++) frame(5'b10000);
    check("miss_s2", score2, 1);
    check("miss_play", playing, 0);
    frame(5'b10000);
    check("point_bx", ball_x, 316);
    check("point_by", ball_y, 236);
    for (int i = 0; i < 60; i++) frame(5'b10000);
    check("relaunch", playing, 1);
    frame(5'b10000);
    check("serve_left", ball_x, 314);

    for (int i = 0; i < 10000 && m_st != 3; i++) frame(chase_buttons());
    check("over", game_over, 1);
    check("win_s2", score2, 9);
    for (int i = 0; i < 100; i++) frame({4'($urandom), 1'b0});
    check("frozen_over", game_over, 1);
    check("frozen_s2", score2, 9);
    frame(5'b00001);
    check("restart_s2", score2, 0);
    check("restart_over", game_over, 0);
    check("restart_p1", paddle1_y, 208);
    check("restart_bx", ball_x, 316);

    for (int i = 0; i < 150; i++) frame(5'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
